// File: rtl/ripple_carry_adder.sv
// Registered ripple-carry adder: a + b + ci through a chain of full-adder cells,
// exposing sum, inter-stage carries and carry-out. Define RCA_OVF_EN to add the signed-overflow output ovf.
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-2:0] co,
  output logic             cout
`ifdef RCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  // There is no valid/ready handshake: operands are taken on every rising
  // edge, and the result for them is on s/co/cout one edge later.

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign c[0] = ci;

  // Each stage waits on the previous stage's carry. The chain is kept strictly
  // serial so the visible carries are the real per-stage ones.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic p;
    assign p        = a[i] ^ b[i];
    assign sum[i]   = p ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & p);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s    <= '0;
      co   <= '0;
      cout <= 1'b0;
    end else begin
      s    <= sum;
      co   <= c[WIDTH-1:1];
      cout <= c[WIDTH];
    end
  end

`ifdef RCA_OVF_EN
  // Overflow occurs when the carry into the sign bit differs from the carry out of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else begin
      ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder: directed corner cases plus a randomized
// stream compared with an arithmetic reference model (ovf checked when RCA_OVF_EN is defined).
module tb_ripple_carry_adder;
  localparam int W  = 4;
  localparam int EW = 2 * W + 1;  // {ovf, cout, co, s}

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic [W-1:0] s;
  logic [W-2:0] co;
  logic         cout;
  logic         ovf_bit;

  int total;
  int bad;
  logic [EW-1:0] exp_q[$];

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .ci   (ci),
    .s    (s),
    .co   (co),
    .cout (cout)
`ifdef RCA_OVF_EN
    ,
    .ovf  (ovf_bit)
`endif
  );

`ifndef RCA_OVF_EN
  assign ovf_bit = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Reference model: integer addition; carry into stage i+1 is the bit that
  // overflows the low (i+1) bits; overflow is a signed range check.
  function automatic logic [EW-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input logic civ);
    longint full, part, mask, sa, sb, ssum;
    logic [W-1:0] sv;
    logic [W-2:0] cov;
    logic         cv, ov;
    full = longint'(av) + longint'(bv) + longint'(civ);
    sv   = full[W-1:0];
    cv   = full[W];
    for (int i = 0; i < W - 1; i++) begin
      mask   = (longint'(1) << (i + 1)) - 1;
      part   = (longint'(av) & mask) + (longint'(bv) & mask) + longint'(civ);
      cov[i] = part[i+1];
    end
`ifdef RCA_OVF_EN
    sa   = av[W-1] ? longint'(av) - (longint'(1) << W) : longint'(av);
    sb   = bv[W-1] ? longint'(bv) - (longint'(1) << W) : longint'(bv);
    ssum = sa + sb + longint'(civ);
    ov   = (ssum > (longint'(1) << (W - 1)) - 1) || (ssum < -(longint'(1) << (W - 1)));
`else
    sa = 0; sb = 0; ssum = 0;
    ov = 1'b0;
`endif
    return {ov, cv, cov, sv};
  endfunction

  // driver: apply inputs at negedge, return #1 after the following rising edge
  task automatic drive_cycle(input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic civ, input logic rv);
    @(negedge clk);
    a = av; b = bv; ci = civ; rst_n = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(4'hF, 4'hF, 1'b1, 1'b0);
      total++;
      if ({ovf_bit, cout, co, s} !== '0) begin
        bad++;
        $display("FAIL reset[%0d]: got ovf=%b cout=%b co=%b s=%h, want all zero",
                 i, ovf_bit, cout, co, s);
      end
    end
  endtask

  task automatic test_sweep();
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(model(W'(k), W'(k), 1'b0));
      drive_cycle(W'(k), W'(k), 1'b0, 1'b1);
      e   = exp_q.pop_front();
      got = {ovf_bit, cout, co, s};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL sweep k=%0d: got %b want %b", k, got, e);
      end
      if (k == 5) begin
        total++;
        if ({cout, co, s} !== {1'b0, 3'b101, 4'hA}) begin
          bad++;
          $display("FAIL spot k=5: got cout=%b co=%b s=%h want 0 101 a", cout, co, s);
        end
      end
      if (k == 9) begin
        total++;
        if ({cout, co, s} !== {1'b1, 3'b001, 4'h2}) begin
          bad++;
          $display("FAIL spot k=9: got cout=%b co=%b s=%h want 1 001 2", cout, co, s);
        end
      end
    end
  endtask

  task automatic test_corners();
    drive_cycle(4'hF, 4'h0, 1'b1, 1'b1);
    total++;
    if ({cout, co, s} !== {1'b1, 3'b111, 4'h0}) begin
      bad++;
      $display("FAIL full_propagate: got cout=%b co=%b s=%h want 1 111 0", cout, co, s);
    end
    drive_cycle(4'hF, 4'hF, 1'b1, 1'b1);
    total++;
    if ({cout, co, s} !== {1'b1, 3'b111, 4'hF}) begin
      bad++;
      $display("FAIL max: got cout=%b co=%b s=%h want 1 111 f", cout, co, s);
    end
    drive_cycle(4'h0, 4'h0, 1'b0, 1'b1);
    total++;
    if ({ovf_bit, cout, co, s} !== '0) begin
      bad++;
      $display("FAIL zero: got ovf=%b cout=%b co=%b s=%h want all zero", ovf_bit, cout, co, s);
    end
  endtask

  task automatic test_back_to_back_reset();
    drive_cycle(4'h3, 4'h4, 1'b0, 1'b1);
    total++;
    if ({cout, co, s} !== {1'b0, 3'b000, 4'h7}) begin
      bad++;
      $display("FAIL b2b_first: got cout=%b co=%b s=%h want 0 000 7", cout, co, s);
    end
    drive_cycle(4'h7, 4'h8, 1'b1, 1'b0);
    total++;
    if ({ovf_bit, cout, co, s} !== '0) begin
      bad++;
      $display("FAIL b2b_reset: got ovf=%b cout=%b co=%b s=%h want all zero",
               ovf_bit, cout, co, s);
    end
    drive_cycle(4'h7, 4'h8, 1'b1, 1'b1);
    total++;
    if ({cout, co, s} !== {1'b1, 3'b111, 4'h0}) begin
      bad++;
      $display("FAIL b2b_after: got cout=%b co=%b s=%h want 1 111 0", cout, co, s);
    end
  endtask

`ifdef RCA_OVF_EN
  task automatic test_overflow();
    drive_cycle(4'h7, 4'h1, 1'b0, 1'b1);
    total++;
    if ({ovf_bit, cout, s} !== {1'b1, 1'b0, 4'h8}) begin
      bad++;
      $display("FAIL ovf_pos: got ovf=%b cout=%b s=%h want 1 0 8", ovf_bit, cout, s);
    end
    drive_cycle(4'h8, 4'hF, 1'b0, 1'b1);
    total++;
    if ({ovf_bit, cout, s} !== {1'b1, 1'b1, 4'h7}) begin
      bad++;
      $display("FAIL ovf_neg: got ovf=%b cout=%b s=%h want 1 1 7", ovf_bit, cout, s);
    end
    drive_cycle(4'h3, 4'h2, 1'b0, 1'b1);
    total++;
    if (ovf_bit !== 1'b0) begin
      bad++;
      $display("FAIL ovf_none: got ovf=%b want 0", ovf_bit);
    end
  endtask
`endif

  task automatic test_random();
    logic [W-1:0]  av, bv;
    logic          civ, rv;
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    for (int n = 0; n < 300; n++) begin
      av  = W'($urandom_range(0, (1 << W) - 1));
      bv  = W'($urandom_range(0, (1 << W) - 1));
      civ = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 15) != 0);
      exp_q.push_back(rv ? model(av, bv, civ) : '0);
      drive_cycle(av, bv, civ, rv);
      e   = exp_q.pop_front();
      got = {ovf_bit, cout, co, s};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL random[%0d] a=%h b=%h ci=%b rst_n=%b: got %b want %b",
                 n, av, bv, civ, rv, got, e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    a = '0; b = '0; ci = 1'b0; rst_n = 1'b0;
    test_reset();
    test_sweep();
    test_corners();
    test_back_to_back_reset();
`ifdef RCA_OVF_EN
    test_overflow();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder.md
Name: ripple_carry_adder

Overview:
- Parameterised ripple-carry adder: chain of full-adder cells adding a, b and carry-in ci.
- Exposes the sum, the internal inter-stage carries and the final carry-out.
- Outputs are registered on one clock with synchronous active-low reset.
- Arithmetic leaf used wherever a small registered adder with visible carry chain is needed (datapath, lab/debug builds).

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- ci  input  1  carry into bit 0.
- s  output  WIDTH  registered sum bits.
- co  output  WIDTH-1  registered internal carries; co[i] = carry out of stage i into stage i+1, for i = 0..WIDTH-2.
- cout  output  1  registered carry out of stage WIDTH-1, the MSB.
- ovf  output  1  registered signed overflow; present only when RCA_OVF_EN is defined.

Behaviour:
- Stage i is a full adder:
  - sum_i = a[i] ^ b[i] ^ c_i
  - c_(i+1) = (a[i] & b[i]) | (c_i & (a[i] ^ b[i]))
  - c_0 = ci.
- Structure is a true ripple chain; no carry-lookahead or carry-select restructuring.
- Registered result: {cout, s} = a + b + ci, computed modulo 2^(WIDTH+1).
- Latency is exactly 1 clock.
  - Inputs sampled at rising edge N appear on s/co/cout after edge N.
  - Outputs hold until the next edge.
- Fully pipelined: new operands are accepted every cycle; there is no handshake and no valid signal.
- Reset:
  - When rst_n=0 at a rising edge, s, co, cout (and ovf) load 0 regardless of inputs.
  - Reset takes priority over any input in the same cycle.
  - Reset asserted mid-stream discards the in-flight result.
  - The first post-reset result appears one edge after rst_n returns to 1.
- Wrap-around:
  - All-ones + all-ones + 1 gives s = all-ones, cout=1, co all 1s.
  - All-ones + 0 + 1 gives s=0, cout=1, co all 1s (full carry propagation through every stage).
- Zero case: 0 + 0 + 0 gives s=0, co=0, cout=0.
- No X propagation from the reset state; outputs are defined from the first reset edge.
- Inputs are unsigned bit vectors; only the optional ovf interprets them as two's complement.

Optional Feature:
- Macro RCA_OVF_EN.
- Defined:
  - Adds output port ovf, registered alongside s.
  - ovf = c_WIDTH ^ c_(WIDTH-1), i.e. two's-complement overflow of a + b + ci.
  - Reset value 0.
- Undefined:
  - Port ovf does not exist; no extra logic.
  - All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 edges with a=4'hF, b=4'hF, ci=1 -> s=0, co=3'b000, cout=0 (ovf=0).
- Equal-operand sweep, ci=0, a=b=k for k=0..15, each stepped every cycle:
  - s = (2k) mod 16, co = k[2:0], cout = k[3], each one edge after the inputs are applied.
  - Spot checks: k=5 -> s=4'hA, co=3'b101, cout=0; k=9 -> s=4'h2, co=3'b001, cout=1.
- Full propagate: a=4'hF, b=4'h0, ci=1 -> s=4'h0, co=3'b111, cout=1.
- Max: a=4'hF, b=4'hF, ci=1 -> s=4'hF, co=3'b111, cout=1.
- Mid-stream reset, back-to-back:
  - Apply a=3,b=4,ci=0 then a=7,b=8,ci=1 on consecutive edges, with rst_n=0 on the second edge.
  - Required: s=4'h7 after edge 1, then all outputs 0 after edge 2.
  - After rst_n=1 and one more edge: s=4'h0, cout=1, co=3'b111.
- Overflow (RCA_OVF_EN defined):
  - a=4'h7, b=4'h1, ci=0 -> s=4'h8, ovf=1, cout=0.
  - a=4'h8, b=4'hF, ci=0 -> s=4'h7, ovf=1, cout=1.
  - a=4'h3, b=4'h2 -> ovf=0.
